// File: rtl/dco_fll_ctrl_if.sv
// Control/status bus between a host and dco_fll_ctrl.
// The controller takes the slave modport; the host or bench takes master.
interface dco_fll_ctrl_if #(
    parameter int unsigned CNT_W = 12
);
    logic             ena;
    logic             start;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             locked;
    logic             done;

    modport master (
        output ena, start, target,
        input  count, busy, locked, done
    );

    modport slave (
        input  ena, start, target,
        output count, busy, locked, done
    );
endinterface

// File: rtl/dco_fll_ctrl.sv
// Frequency-locked-loop controller for an 8-bit DCO code.
// Counts DCO rising edges over a 2^WINDOW_LOG2 clk window and SAR-searches
// the code until the count matches bus.target. Tracking after lock
// (+/-1 code steps outside a TOL dead-band) is built only when the
// FLL_TRACK_EN macro is defined; otherwise LOCK is terminal.
module dco_fll_ctrl #(
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned WINDOW_LOG2 = 8,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TOL         = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    dco_fll_ctrl_if.slave bus,
    input  logic          dco_in,
    output logic [7:0]    dco_code
);

    localparam int unsigned WIN_LEN = 1 << WINDOW_LOG2;
    localparam int unsigned TMR_MAX = (WIN_LEN > SETTLE_CYC) ? WIN_LEN : SETTLE_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

    // Reject parameter sets the timers and dead-band compare cannot represent.
    if (SETTLE_CYC == 0 || WINDOW_LOG2 == 0 || CNT_W < 2 || TOL >= (1 << CNT_W)) begin : g_bad_param
        $error("dco_fll_ctrl: unsupported parameter combination");
    end

`ifdef FLL_TRACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE, S_LOCK,
        S_TSETTLE, S_TMEASURE, S_TDECIDE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE, S_LOCK
    } state_t;
`endif

    state_t           state;
    logic [2:0]       bit_idx;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             locked_q;
    logic             done_q;
    logic             s0, s1, s2;

    // Two-flop synchronizer plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s2, s1, s0} <= 3'b000;
        end else begin
            {s2, s1, s0} <= {s1, s0, dco_in};
        end
    end

    logic             dco_rise_c;
    logic [CNT_W-1:0] edge_next_c;
    assign dco_rise_c  = s1 & ~s2;
    // Saturating edge count including the edge seen this cycle.
    assign edge_next_c = (dco_rise_c && (edge_cnt != CNT_SAT)) ? edge_cnt + CNT_W'(1) : edge_cnt;

    logic [7:0] bit_mask_c;
    logic [7:0] trial_c;
    logic       over_c;
    assign bit_mask_c = 8'h01 << bit_idx;
    assign over_c     = count_q > bus.target;
    // Trial bit is dropped only when the DCO ran strictly fast; equality keeps it.
    assign trial_c    = over_c ? (dco_code & ~bit_mask_c) : dco_code;

`ifdef FLL_TRACK_EN
    localparam int unsigned XW = CNT_W + 1;
    logic [CNT_W:0] cnt_x_c;
    logic [CNT_W:0] tgt_x_c;
    logic [CNT_W:0] tol_x_c;
    logic           above_c;
    logic           below_c;
    // One extra bit so target + TOL and count + TOL cannot overflow.
    assign cnt_x_c = {1'b0, count_q};
    assign tgt_x_c = {1'b0, bus.target};
    assign tol_x_c = XW'(TOL);
    assign above_c = cnt_x_c > (tgt_x_c + tol_x_c);
    assign below_c = (cnt_x_c + tol_x_c) < tgt_x_c;
`endif

    logic start_ok_c;
`ifdef FLL_TRACK_EN
    assign start_ok_c = (state == S_IDLE) || (state == S_LOCK) || (state == S_TSETTLE) ||
                        (state == S_TMEASURE) || (state == S_TDECIDE);
`else
    assign start_ok_c = (state == S_IDLE) || (state == S_LOCK);
`endif

    // Search/track sequencer with registered code and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_idx  <= 3'd7;
            tmr      <= '0;
            edge_cnt <= '0;
            count_q  <= '0;
            dco_code <= 8'h00;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!bus.ena) begin
                state    <= S_IDLE;
                busy_q   <= 1'b0;
                locked_q <= 1'b0;
                tmr      <= '0;
            end else if (bus.start && start_ok_c) begin
                state    <= S_SETTLE;
                dco_code <= 8'h80;
                bit_idx  <= 3'd7;
                tmr      <= '0;
                busy_q   <= 1'b1;
                locked_q <= 1'b0;
            end else begin
                case (state)
                    S_SETTLE: begin
                        if (tmr == SETTLE_LAST) begin
                            tmr      <= '0;
                            edge_cnt <= '0;
                            state    <= S_MEASURE;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    S_MEASURE: begin
                        edge_cnt <= edge_next_c;
                        if (tmr == WIN_LAST) begin
                            tmr     <= '0;
                            count_q <= edge_next_c;
                            state   <= S_DECIDE;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    S_DECIDE: begin
                        if (bit_idx == 3'd0) begin
                            dco_code <= trial_c;
                            done_q   <= 1'b1;
                            locked_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state    <= S_LOCK;
                        end else begin
                            dco_code <= trial_c | (bit_mask_c >> 1);
                            bit_idx  <= bit_idx - 3'd1;
                            tmr      <= '0;
                            state    <= S_SETTLE;
                        end
                    end
                    S_LOCK: begin
                        tmr <= '0;
`ifdef FLL_TRACK_EN
                        state <= S_TSETTLE;
`endif
                    end
`ifdef FLL_TRACK_EN
                    S_TSETTLE: begin
                        if (tmr == SETTLE_LAST) begin
                            tmr      <= '0;
                            edge_cnt <= '0;
                            state    <= S_TMEASURE;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    S_TMEASURE: begin
                        edge_cnt <= edge_next_c;
                        if (tmr == WIN_LAST) begin
                            tmr     <= '0;
                            count_q <= edge_next_c;
                            state   <= S_TDECIDE;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    S_TDECIDE: begin
                        if (above_c) begin
                            if (dco_code != 8'h00) begin
                                dco_code <= dco_code - 8'd1;
                            end
                            locked_q <= 1'b0;
                        end else if (below_c) begin
                            if (dco_code != 8'hFF) begin
                                dco_code <= dco_code + 8'd1;
                            end
                            locked_q <= 1'b0;
                        end else begin
                            locked_q <= 1'b1;
                        end
                        tmr   <= '0;
                        state <= S_TSETTLE;
                    end
`endif
                    S_IDLE: begin
                        tmr <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.count  = count_q;
    assign bus.busy   = busy_q;
    assign bus.locked = locked_q;
    assign bus.done   = done_q;

endmodule
